// File: rtl/log2_fixed_iter.sv
// Iterative fixed-point log2: normalise to a Q1.x mantissa, then square-and-compare
// to produce one fractional bit per cycle. Valid/ready on both sides with a tag.
module log2_fixed_iter #(
   parameter int IN_WIDTH  = 24,
   parameter int IN_FRAC   = 8,
   parameter int OUT_FRAC  = 8,
   parameter int OUT_WIDTH = 13,
   parameter int TAG_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  din,
   input  logic [TAG_WIDTH-1:0] din_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] dout,
   output logic [TAG_WIDTH-1:0] dout_tag,
   output logic                 dout_zero,
   output logic [1:0]           state_dbg
);

   // Handshake: a transfer happens on a rising edge where valid && ready; the
   // producer holds data stable while valid is high and ready is low.

   localparam int PW = $clog2(IN_WIDTH);
   localparam int CW = $clog2(OUT_FRAC + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] NORM = 2'd1;
   localparam logic [1:0] ITER = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [OUT_WIDTH-1:0] ZERO_CODE = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   logic [1:0]                state;
   logic                      norm_step;
   logic [IN_WIDTH-1:0]       mant;
   logic [PW-1:0]             msb_pos;
   logic [PW-1:0]             msb_reg;
   logic [PW-1:0]             shamt;
   logic                      op_zero;
   logic [OUT_FRAC-1:0]       frac;
   logic [OUT_FRAC-1:0]       frac_next;
   logic [CW-1:0]             cnt;
   logic [IN_WIDTH:0]         sq_hi;
   logic [IN_WIDTH-2:0]       sq_unused;
   logic                      sq_bit;
   logic [IN_WIDTH-1:0]       mant_sq;
   logic [OUT_WIDTH-1:0]      int_ext;
   logic [OUT_WIDTH-1:0]      dout_next;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign state_dbg = state;

   always_comb begin
      msb_pos = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
         if (mant[i]) msb_pos = PW'(i);
      end
   end

   assign shamt = PW'(IN_WIDTH - 1) - msb_reg;

   // Only the top W+1 bits of the square matter: bit 2W-1 decides the output
   // bit, and the renormalised mantissa is one of two adjacent W-bit windows.
   assign {sq_hi, sq_unused} = {{IN_WIDTH{1'b0}}, mant} * {{IN_WIDTH{1'b0}}, mant};
   assign sq_bit    = sq_hi[IN_WIDTH];
   assign mant_sq   = sq_bit ? sq_hi[IN_WIDTH:1] : sq_hi[IN_WIDTH-1:0];
   assign frac_next = OUT_FRAC'({frac, sq_bit});

   assign int_ext   = OUT_WIDTH'(msb_reg) - OUT_WIDTH'(IN_FRAC);
   assign dout_next = (int_ext << OUT_FRAC) | OUT_WIDTH'(frac_next);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         norm_step <= 1'b0;
         mant      <= '0;
         msb_reg   <= '0;
         op_zero   <= 1'b0;
         frac      <= '0;
         cnt       <= '0;
         dout      <= '0;
         dout_tag  <= '0;
         dout_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mant      <= din;
                  dout_tag  <= din_tag;
                  norm_step <= 1'b0;
                  state     <= NORM;
               end
            end
            // Two cycles: register the leading-one position, then barrel-shift.
            NORM: begin
               if (!norm_step) begin
                  msb_reg   <= msb_pos;
                  op_zero   <= (mant == '0);
                  norm_step <= 1'b1;
               end else if (op_zero) begin
                  dout      <= ZERO_CODE;
                  dout_zero <= 1'b1;
                  state     <= DONE;
               end else begin
                  mant  <= mant << shamt;
                  frac  <= '0;
                  cnt   <= '0;
                  state <= ITER;
               end
            end
            ITER: begin
               mant <= mant_sq;
               frac <= frac_next;
               cnt  <= cnt + CW'(1);
               if (cnt == CW'(OUT_FRAC - 1)) begin
                  dout      <= dout_next;
                  dout_zero <= 1'b0;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
